// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline sequencer for the 5-stage RV32I core (fetch/decode/execute/
//   memory/write-back). Keeps a 3-slot scoreboard of in-flight instructions
//   (EX, MEM, WB) and derives PC / IF-ID write enables, stage flushes and the
//   EX operand forwarding selects. Branches resolve in the MEM stage.
//
// Build option:
//   FORWARDING_EN  defined   -> EX operand forwarding; only load-use stalls (1 cycle)
//                  undefined -> no forwarding; any RAW on EX/MEM stalls (up to 2 cycles)
//
// Parameters:
//   RA_W   register address width
//   CNT_W  width of the stall-cycle performance counter
//
// Ports:
//   clk, rst                core clock, asynchronous active-high reset
//   i_id_*                  decode-stage instruction info (valid, rs1/rs2 + use flags,
//                           rd, reg_write, mem_read)
//   i_mem_branch_taken      taken branch resolved in MEM
//   o_pc_write              fetch load_next_pc enable
//   o_if_id_write           IF/ID register enable
//   o_if_id_flush           bubble into IF/ID
//   o_id_ex_flush           bubble into ID/EX
//   o_ex_mem_flush          bubble into EX/MEM
//   o_fwd_a / o_fwd_b       EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   o_stall_cnt             saturating count of stall cycles
//
// State table:
//   S_RESET | held after reset; fetch frozen, every stage flushed
//   S_RUN   | normal issue (also the state after a branch squash)
//   S_STALL | the decode instruction is waiting on a RAW hazard

module hazard_control #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_id_valid,
  input  logic [RA_W-1:0]  i_id_rs1,
  input  logic [RA_W-1:0]  i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [RA_W-1:0]  i_id_rd,
  input  logic             i_id_reg_write,
  input  logic             i_id_mem_read,
  input  logic             i_mem_branch_taken,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_flush,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_read;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            use_rs1;
    logic            use_rs2;
  } slot_t;

  state_t           r_state;
  state_t           w_state_nxt;
  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  slot_t            w_id_slot;
  logic             w_hazard;
  logic             w_stall;
  logic             w_branch;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_unused;

  // A slot produces register r for a consumer that actually reads it.
  function automatic logic f_match(input slot_t s, input logic [RA_W-1:0] r,
                                   input logic used);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r) & used;
  endfunction

  // rd == x0 is folded into reg_write so x0 never looks like a producer.
  always_comb begin
    w_id_slot           = '0;
    w_id_slot.valid     = i_id_valid;
    w_id_slot.rd        = i_id_rd;
    w_id_slot.reg_write = i_id_reg_write & (i_id_rd != '0);
    w_id_slot.mem_read  = i_id_mem_read;
    w_id_slot.rs1       = i_id_rs1;
    w_id_slot.rs2       = i_id_rs2;
    w_id_slot.use_rs1   = i_id_uses_rs1;
    w_id_slot.use_rs2   = i_id_uses_rs2;
  end

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time.
  assign w_hazard = r_ex.mem_read &
                    (f_match(r_ex, i_id_rs1, i_id_uses_rs1) |
                     f_match(r_ex, i_id_rs2, i_id_uses_rs2));

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_ex.valid) begin
      if (f_match(r_mem, r_ex.rs1, r_ex.use_rs1))     w_fwd_a = 2'b10;
      else if (f_match(r_wb, r_ex.rs1, r_ex.use_rs1)) w_fwd_a = 2'b01;
      if (f_match(r_mem, r_ex.rs2, r_ex.use_rs2))     w_fwd_b = 2'b10;
      else if (f_match(r_wb, r_ex.rs2, r_ex.use_rs2)) w_fwd_b = 2'b01;
    end
  end
`else
  // WB is excluded: the register file writes through in the same cycle.
  assign w_hazard = f_match(r_ex,  i_id_rs1, i_id_uses_rs1) |
                    f_match(r_ex,  i_id_rs2, i_id_uses_rs2) |
                    f_match(r_mem, i_id_rs1, i_id_uses_rs1) |
                    f_match(r_mem, i_id_rs2, i_id_uses_rs2);
  assign w_fwd_a  = 2'b00;
  assign w_fwd_b  = 2'b00;
`endif

  // Not every slot field feeds logic in every build.
  assign w_unused = ^{r_ex, r_mem, r_wb};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_flush = 1'b0;
    o_fwd_a        = 2'b00;
    o_fwd_b        = 2'b00;
    w_stall        = 1'b0;
    w_branch       = 1'b0;
    case (r_state)
      S_RESET: begin
        o_pc_write     = 1'b0;
        o_if_id_write  = 1'b0;
        o_if_id_flush  = 1'b1;
        o_id_ex_flush  = 1'b1;
        o_ex_mem_flush = 1'b1;
        w_state_nxt    = S_RUN;
      end
      S_RUN, S_STALL: begin
        w_stall  = w_hazard;
        w_branch = i_mem_branch_taken;
        o_fwd_a  = w_fwd_a;
        o_fwd_b  = w_fwd_b;
        if (w_branch) begin
          // The stalled decode instruction is on the wrong path; squash it.
          o_if_id_flush  = 1'b1;
          o_id_ex_flush  = 1'b1;
          o_ex_mem_flush = 1'b1;
          w_state_nxt    = S_RUN;
        end else if (w_stall) begin
          o_pc_write    = 1'b0;
          o_if_id_write = 1'b0;
          o_id_ex_flush = 1'b1;
          w_state_nxt   = S_STALL;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Scoreboard follows the flush outputs so it always mirrors the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= o_ex_mem_flush ? '0 : r_ex;
      r_ex  <= o_id_ex_flush  ? '0 : w_id_slot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_branch && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule
